// File: rtl/m68k_bus_decoder.sv
// m68k_bus_decoder
// Registered address decoder and bus-cycle controller for the 68000 side of
// arcade cores. A programmable table of base/mask regions is decoded once at
// the start of each CPU bus cycle. The block then steps through per-region
// wait states and an optional external ready handshake, and it ends the
// cycle with DTACK_n. Unmapped or stalled accesses time out with BERR_n.
//
// Cycle flow:
//   IDLE --as_n low--> WAIT --wait done & ready--> ACK --as_n high--> IDLE
//                          --timeout-------------> ERR --as_n high--> IDLE
//                          --as_n high (abort)---------------------> IDLE
//
// NUM_REGIONS must be at least 2 so hit_idx has a non-zero width.
// TIMEOUT must be in the range 2..1023 so the timeout counter can reach it.

module m68k_bus_decoder #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ADDR_W-1:0]               cpu_a,
  input  logic                            cpu_as_n,
  input  logic [NUM_REGIONS*ADDR_W-1:0]   region_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0]   region_mask,
  input  logic [NUM_REGIONS*WAIT_W-1:0]   region_wait,
  input  logic [NUM_REGIONS-1:0]          region_en,
  input  logic [NUM_REGIONS-1:0]          region_ready,
  output logic [NUM_REGIONS-1:0]          cs,
  output logic [$clog2(NUM_REGIONS)-1:0]  hit_idx,
  output logic                            dtack_n,
  output logic                            berr_n,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_REGIONS);
  localparam int TO_W  = 10;

  // The last count value seen in WAIT before the timeout fires.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  // Decode results for the address currently on the bus.
  logic [NUM_REGIONS-1:0] w_hit_vec;
  logic                   w_hit;
  logic [IDX_W-1:0]       w_hit_idx;
  logic [WAIT_W-1:0]      w_hit_wait;
  logic [NUM_REGIONS-1:0] w_cs_next;

  // Ready line of the region latched for the cycle in progress.
  logic                   w_ready_sel;

  // Cycle state.
  state_t                 r_state;
  logic [NUM_REGIONS-1:0] r_cs;
  logic [IDX_W-1:0]       r_hit_idx;
  logic                   r_hit;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_dtack_n;
  logic                   r_berr_n;
  logic                   r_busy;

  // Compare the bus address against every enabled region in parallel.
  // NOTE: every signal written in an always_comb gets a default value first.
  // A path that skips the assignment would otherwise infer a latch.
  always_comb begin
    w_hit_vec = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      w_hit_vec[k] = region_en[k] &&
        (((cpu_a ^ region_base[k*ADDR_W +: ADDR_W]) &
          region_mask[k*ADDR_W +: ADDR_W]) == '0);
    end
  end

  // Priority-encode the hits. The loop scans downwards, so the lowest index wins.
  always_comb begin
    w_hit      = |w_hit_vec;
    w_hit_idx  = '0;
    w_hit_wait = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (w_hit_vec[k]) begin
        w_hit_idx  = IDX_W'(k);
        w_hit_wait = region_wait[k*WAIT_W +: WAIT_W];
      end
    end
  end

  // Build the one-hot chip select for the winning region. It is zero on a miss.
  always_comb begin
    w_cs_next = '0;
    if (w_hit) begin
      w_cs_next = NUM_REGIONS'(1) << w_hit_idx;
    end
  end

  // Select the ready line of the region latched at cycle start.
  always_comb begin
    w_ready_sel = 1'b0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (IDX_W'(k) == r_hit_idx) begin
        w_ready_sel = region_ready[k];
      end
    end
  end

  // Bus-cycle FSM. All outputs are registered here alongside the state.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from the values it held before the edge, whatever the
  // statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cs       <= '0;
      r_hit_idx  <= '0;
      r_hit      <= 1'b0;
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
      r_dtack_n  <= 1'b1;
      r_berr_n   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Latch the decode and the wait count once. Later changes to the
          // address or the region table do not affect this cycle.
          if (!cpu_as_n) begin
            r_state    <= S_WAIT;
            r_busy     <= 1'b1;
            r_cs       <= w_cs_next;
            r_hit      <= w_hit;
            r_hit_idx  <= w_hit_idx;
            r_wait_cnt <= w_hit ? w_hit_wait : '0;
            r_to_cnt   <= '0;
          end
        end

        S_WAIT: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (cpu_as_n) begin
            // The CPU abandoned the cycle. Return quietly without dtack or berr.
            r_state <= S_IDLE;
            r_cs    <= '0;
            r_busy  <= 1'b0;
          end else if (r_to_cnt == TO_LAST) begin
            r_state  <= S_ERR;
            r_cs     <= '0;
            r_berr_n <= 1'b0;
          end else if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end else if (r_hit && w_ready_sel) begin
            r_state   <= S_ACK;
            r_dtack_n <= 1'b0;
          end
        end

        S_ACK: begin
          // Hold dtack and cs until the CPU drops the address strobe.
          if (cpu_as_n) begin
            r_state   <= S_IDLE;
            r_cs      <= '0;
            r_dtack_n <= 1'b1;
            r_busy    <= 1'b0;
          end
        end

        S_ERR: begin
          if (cpu_as_n) begin
            r_state  <= S_IDLE;
            r_berr_n <= 1'b1;
            r_busy   <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_cs      <= '0;
          r_dtack_n <= 1'b1;
          r_berr_n  <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign cs      = r_cs;
  assign hit_idx = r_hit_idx;
  assign dtack_n = r_dtack_n;
  assign berr_n  = r_berr_n;
  assign busy    = r_busy;

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// Testbench for m68k_bus_decoder.
// Each access is predicted at transaction level from the region table kept
// in the bench. The prediction is: which region wins, on which edge dtack or
// berr appears, and on which edge the outputs release. The prediction is then
// compared with the DUT outputs after every clock edge of the access.

module tb_m68k_bus_decoder;

  localparam int NR = 8;
  localparam int AW = 24;
  localparam int WW = 4;
  localparam int TO = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [AW-1:0]         cpu_a;
  logic                  cpu_as_n;
  logic [NR*AW-1:0]      region_base;
  logic [NR*AW-1:0]      region_mask;
  logic [NR*WW-1:0]      region_wait;
  logic [NR-1:0]         region_en;
  logic [NR-1:0]         region_ready;
  logic [NR-1:0]         cs;
  logic [$clog2(NR)-1:0] hit_idx;
  logic                  dtack_n;
  logic                  berr_n;
  logic                  busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference region table.
  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_mask [NR];
  logic [WW-1:0] m_wait [NR];
  logic          m_en   [NR];

  logic [AW-1:0] mask_pool [4] = '{24'hFF0000, 24'hF00000, 24'hFFC000, 24'hFFFFF0};

  m68k_bus_decoder #(
    .NUM_REGIONS (NR),
    .ADDR_W      (AW),
    .WAIT_W      (WW),
    .TIMEOUT     (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_a        (cpu_a),
    .cpu_as_n     (cpu_as_n),
    .region_base  (region_base),
    .region_mask  (region_mask),
    .region_wait  (region_wait),
    .region_en    (region_en),
    .region_ready (region_ready),
    .cs           (cs),
    .hit_idx      (hit_idx),
    .dtack_n      (dtack_n),
    .berr_n       (berr_n),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input logic [NR-1:0] e_cs, input logic e_dtack,
                               input logic e_berr, input logic e_busy, input int e_idx);
    check({tag, " cs"}, 32'(cs), 32'(e_cs));
    check({tag, " dtack_n"}, 32'(dtack_n), 32'(e_dtack));
    check({tag, " berr_n"}, 32'(berr_n), 32'(e_berr));
    check({tag, " busy"}, 32'(busy), 32'(e_busy));
    if (e_cs != '0) check({tag, " hit_idx"}, 32'(hit_idx), 32'(e_idx));
  endtask

  // Move one full clock. Inputs are driven at the falling edge and outputs are
  // sampled there as well.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_table();
    for (int k = 0; k < NR; k++) begin
      region_base[k*AW +: AW] = m_base[k];
      region_mask[k*AW +: AW] = m_mask[k];
      region_wait[k*WW +: WW] = m_wait[k];
      region_en[k]            = m_en[k];
    end
  endtask

  // Find the lowest-numbered enabled region whose masked bits match the address.
  function automatic void model_decode(input logic [AW-1:0] a, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int k = 0; k < NR; k++) begin
      if (!hit && m_en[k] && (((a ^ m_base[k]) & m_mask[k]) == '0)) begin
        hit = 1'b1;
        idx = k;
      end
    end
  endfunction

  // Run one CPU access.
  //   ready_low : ready is low on edges 1..ready_low
  //   abort_at  : as_n is sampled high on this edge (0 = no abort)
  //   hold      : extra edges as_n stays low after dtack/berr
  task automatic do_access(input string name, input logic [AW-1:0] addr,
                           input int ready_low, input int abort_at, input int hold);
    bit            hit;
    int            idx;
    int            w;
    int            ack;
    int            term;
    int            last;
    bit            aborted;
    logic [NR-1:0] oh;
    model_decode(addr, hit, idx);
    w   = hit ? int'(m_wait[idx]) : 0;
    ack = -1;
    if (hit) begin
      ack = (w + 1 > ready_low + 1) ? w + 1 : ready_low + 1;
      if (ack >= TO) ack = -1;
    end
    term    = (ack > 0) ? ack : TO;
    aborted = (abort_at > 0) && (abort_at <= term);
    last    = aborted ? abort_at : term + 1 + hold;
    oh      = hit ? (NR'(1) << idx) : '0;
    apply_table();
    for (int e = 0; e <= last; e++) begin
      if (e == 0) begin
        cpu_a        = addr;
        cpu_as_n     = 1'b0;
        region_ready = {NR{1'b1}};
      end else begin
        // Disturb the address and the table mid-cycle. The latched decode
        // must not react to these changes.
        cpu_a = AW'($urandom);
        for (int k = 0; k < NR; k++) region_base[k*AW +: AW] = AW'($urandom);
        region_en    = NR'($urandom);
        cpu_as_n     = (e >= last);
        region_ready = (e <= ready_low) ? {NR{1'b0}} : {NR{1'b1}};
      end
      tick();
      if (e >= last)
        check_outputs($sformatf("%s e%0d idle", name, e), '0, 1'b1, 1'b1, 1'b0, 0);
      else if (e < term)
        check_outputs($sformatf("%s e%0d wait", name, e), oh, 1'b1, 1'b1, 1'b1, idx);
      else if (ack > 0)
        check_outputs($sformatf("%s e%0d ack", name, e), oh, 1'b0, 1'b1, 1'b1, idx);
      else
        check_outputs($sformatf("%s e%0d err", name, e), '0, 1'b1, 1'b0, 1'b1, idx);
    end
    apply_table();
    region_ready = {NR{1'b1}};
  endtask

  task automatic random_table();
    for (int k = 0; k < NR; k++) begin
      m_base[k] = AW'($urandom);
      m_mask[k] = mask_pool[$urandom_range(0, 3)];
      m_wait[k] = WW'($urandom_range(0, 6));
      m_en[k]   = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic [AW-1:0] addr;
    int            j;

    // Directed region table.
    for (int k = 0; k < NR; k++) begin
      m_base[k] = '0;
      m_mask[k] = '0;
      m_wait[k] = '0;
      m_en[k]   = 1'b0;
    end
    m_base[0] = 24'h000000; m_mask[0] = 24'hFC0000; m_wait[0] = 4'd0; m_en[0] = 1'b1;
    m_base[1] = 24'h070000; m_mask[1] = 24'hFF0000; m_wait[1] = 4'd1; m_en[1] = 1'b1;
    m_base[2] = 24'h200000; m_mask[2] = 24'hF00000; m_wait[2] = 4'd0; m_en[2] = 1'b1;
    m_base[3] = 24'h0E0040; m_mask[3] = 24'hFFFFFE; m_wait[3] = 4'd3; m_en[3] = 1'b1;
    m_base[4] = 24'h400000; m_mask[4] = 24'hFF0000; m_wait[4] = 4'd8; m_en[4] = 1'b1;
    m_base[5] = 24'h070000; m_mask[5] = 24'hFFC000; m_wait[5] = 4'd2; m_en[5] = 1'b1;
    apply_table();
    cpu_a        = '0;
    cpu_as_n     = 1'b0;
    region_ready = {NR{1'b1}};
    reset_n      = 1'b0;

    // Reset state. as_n is low during reset but must not start a cycle.
    @(negedge clk);
    tick();
    check_outputs("reset", '0, 1'b1, 1'b1, 1'b0, 0);
    check("reset hit_idx", 32'(hit_idx), 32'd0);
    cpu_as_n = 1'b1;
    reset_n  = 1'b1;
    tick();
    tick();
    check_outputs("post_reset idle", '0, 1'b1, 1'b1, 1'b0, 0);

    // Directed cases.
    do_access("r0_read", 24'h01FFFE, 0, 0, 0);
    do_access("r0_hold", 24'h000010, 0, 0, 2);
    do_access("r3_wait3", 24'h0E0041, 0, 0, 1);
    do_access("overlap", 24'h070010, 0, 0, 0);
    do_access("unmapped", 24'h123456, 0, 0, 1);
    do_access("r2_ready5", 24'h200010, 5, 0, 0);
    do_access("r2_noready", 24'h200010, 99, 0, 0);
    do_access("r4_abort", 24'h400000, 0, 3, 0);

    // Reset pulsed during ACK clears the outputs immediately.
    apply_table();
    cpu_a    = 24'h000100;
    cpu_as_n = 1'b0;
    tick();
    tick();
    check_outputs("pre_rst ack", 8'h01, 1'b0, 1'b1, 1'b1, 0);
    #2 reset_n = 1'b0;
    #1 check_outputs("async_rst", '0, 1'b1, 1'b1, 1'b0, 0);
    check("async_rst hit_idx", 32'(hit_idx), 32'd0);
    cpu_as_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check_outputs("rst_release idle", '0, 1'b1, 1'b1, 1'b0, 0);
    do_access("after_rst", 24'h03FF00, 0, 0, 0);

    // Wait-count boundaries against the timeout.
    m_wait[3] = 4'd14;
    do_access("r3_wait14", 24'h0E0040, 0, 0, 0);
    m_wait[4] = 4'd15;
    do_access("r4_wait15", 24'h40ABCD, 0, 0, 0);

    // Randomized accesses against the model.
    for (int t = 0; t < 40; t++) begin
      if (t % 5 == 0) random_table();
      j = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 3) != 0)
        addr = m_base[j] ^ (AW'($urandom) & ~m_mask[j]);
      else
        addr = AW'($urandom);
      do_access($sformatf("rnd%0d", t), addr, $urandom_range(0, 5),
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0,
                $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
